// File: rtl/zxnet_pkg.sv
// rtl/zxnet_pkg.sv - shared constants, FSM state enum and port-hit decode for the ZX bus port block.
package zxnet_pkg;

  localparam logic [1:0] PORT_81AB = 2'b01;
  localparam logic [1:0] PORT_82AB = 2'b10;
  localparam logic [1:0] PORT_83AB = 2'b11;

  localparam logic [7:0] ZX_LOW_BYTE  = 8'hAB;
  localparam logic [5:0] ZX_HI_PREFIX = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WSETUP,
    ST_WSTB,
    ST_RDRIVE,
    ST_WAITEND
  } zx_state_t;

  // Decodes #81AB/#82AB/#83AB; #80AB shares the prefix but is not a port.
  function automatic logic zx_port_hit(input logic [15:0] a);
    return (a[7:0] == ZX_LOW_BYTE) && (a[15:10] == ZX_HI_PREFIX) &&
           (a[9:8] inside {PORT_81AB, PORT_82AB, PORT_83AB});
  endfunction

endpackage

// File: rtl/zx_sync2.sv
// rtl/zx_sync2.sv - 2-FF synchronizer; resets to all-ones because the ZX control lines idle high.
module zx_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         wrstb_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge wrstb_n) begin
    if (wrstb_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zxbus_port_ctrl.sv
// rtl/zxbus_port_ctrl.sv - ZX bus I/O decoder for ports #81AB..#83AB with a timed write strobe
// and a registered read driver.
module zxbus_port_ctrl
  import zxnet_pkg::*;
#(
  parameter int STB_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        wrstb_n,
  input  logic [15:0] zx_a,
  input  logic        zx_iorq_n,
  input  logic        zx_rd_n,
  input  logic        zx_wr_n,
  input  logic        zx_m1_n,
  input  logic [7:0]  zx_d_in,
  output logic [7:0]  zx_d_out,
  output logic        zx_d_oe,
  output logic [1:0]  port_addr,
  output logic [7:0]  port_wrdata,
  output logic        port_wrena,
  output logic        port_wrstb_n,
  input  logic [7:0]  port_rddata
);

  localparam logic [7:0] STB_LAST = 8'(STB_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  logic [3:0] sync_q;
  logic       s_iorq, s_rd, s_wr, s_m1;
  logic       bus_idle, cyc_req;

  zx_state_t  state;
  logic [7:0] cnt;
  logic       armed;

  zx_sync2 #(.W(4)) u_sync (
    .clk     (clk),
    .wrstb_n (wrstb_n),
    .d       ({zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n}),
    .q       (sync_q)
  );

  assign {s_iorq, s_rd, s_wr, s_m1} = sync_q;
  assign bus_idle = s_iorq && s_rd && s_wr;
  // INTA (m1 low) never qualifies; rd=wr=0 still counts so it gets parked in WAITEND.
  assign cyc_req  = !s_iorq && s_m1 && !(s_rd && s_wr);

  // Async reset drops port_wrena together with the strobe rise, so an aborted write latches nothing.
  always_ff @(posedge clk or posedge wrstb_n) begin
    if (wrstb_n) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      armed        <= 1'b0;
      port_addr    <= 2'b00;
      port_wrdata  <= 8'h00;
      port_wrena   <= 1'b0;
      port_wrstb_n <= 1'b1;
      zx_d_oe      <= 1'b0;
      zx_d_out     <= 8'h00;
    end else begin
      cnt <= cnt + 8'd1;
      case (state)
        ST_IDLE: begin
          cnt <= 8'd0;
          if (s_iorq) armed <= 1'b1;
          if (armed && cyc_req) begin
            if (!s_rd && !s_wr) begin
              state <= ST_WAITEND;
            end else if (zx_port_hit(zx_a)) begin
              port_addr <= zx_a[9:8];
              if (!s_wr) begin
                port_wrdata <= zx_d_in;
                port_wrena  <= 1'b1;
                state       <= ST_WSETUP;
              end else begin
                zx_d_oe <= 1'b1;
                state   <= ST_RDRIVE;
              end
            end else begin
              state <= ST_WAITEND;
            end
          end
        end

        ST_WSETUP: begin
          port_wrstb_n <= 1'b0;
          cnt          <= 8'd0;
          state        <= ST_WSTB;
        end

        ST_WSTB: begin
          if (cnt == STB_LAST) begin
            port_wrstb_n <= 1'b1;
            cnt          <= 8'd0;
            state        <= ST_WAITEND;
          end
        end

        ST_RDRIVE: begin
          zx_d_out <= port_rddata;
          if (s_iorq || s_rd || (cnt == TO_LAST)) begin
            zx_d_oe <= 1'b0;
            cnt     <= 8'd0;
            armed   <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        ST_WAITEND: begin
          // Held one cycle past the strobe rise so the register file sees a stable qualifier.
          port_wrena <= 1'b0;
          if (bus_idle || (cnt == TO_LAST)) begin
            cnt   <= 8'd0;
            armed <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          cnt   <= 8'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zxbus_port_ctrl.sv
// tb/tb_zxbus_port_ctrl.sv - scoreboard bench: stimulus queues expected strobe/read events, a negedge monitor pops and compares.
module tb_zxbus_port_ctrl;

  logic        clk = 1'b0;
  logic        wrstb_n;
  logic [15:0] zx_a;
  logic        zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n;
  logic [7:0]  zx_d_in;
  logic [7:0]  zx_d_out;
  logic        zx_d_oe;
  logic [1:0]  port_addr;
  logic [7:0]  port_wrdata;
  logic        port_wrena;
  logic        port_wrstb_n;
  logic [7:0]  port_rddata;

  always #5 clk = ~clk;

  assign port_rddata = (port_addr == 2'b01) ? 8'h5A :
                       (port_addr == 2'b10) ? 8'hE5 : 8'hC3;

  zxbus_port_ctrl #(.STB_CYCLES(2), .TIMEOUT(255)) dut (
    .clk          (clk),
    .wrstb_n      (wrstb_n),
    .zx_a         (zx_a),
    .zx_iorq_n    (zx_iorq_n),
    .zx_rd_n      (zx_rd_n),
    .zx_wr_n      (zx_wr_n),
    .zx_m1_n      (zx_m1_n),
    .zx_d_in      (zx_d_in),
    .zx_d_out     (zx_d_out),
    .zx_d_oe      (zx_d_oe),
    .port_addr    (port_addr),
    .port_wrdata  (port_wrdata),
    .port_wrena   (port_wrena),
    .port_wrstb_n (port_wrstb_n),
    .port_rddata  (port_rddata)
  );

  typedef struct {
    bit         is_rd;
    logic [1:0] addr;
    logic [7:0] data;
    logic       wrena;
    int         width;
    int         lat;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  rd_rel_cyc = 0;
  int  oe_rises = 0;
  int  wrena_rises = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input ev_t g);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", 32'(g.is_rd), 32'(e.is_rd));
    check("ev_addr", 32'(g.addr), 32'(e.addr));
    check("ev_data", 32'(g.data), 32'(e.data));
    check("ev_wrena", 32'(g.wrena), 32'(e.wrena));
    if (e.width >= 0) check("ev_width", 32'(g.width), 32'(e.width));
    if (e.lat >= 0) check("ev_oe_drop_within", 32'(g.lat <= e.lat), 32'd1);
  endtask

  function automatic ev_t mk(input bit r, input logic [1:0] a, input logic [7:0] d,
                             input logic w, input int wd, input int lt);
    ev_t e;
    e.is_rd = r; e.addr = a; e.data = d; e.wrena = w; e.width = wd; e.lat = lt;
    return e;
  endfunction

  // Monitor: one event per strobe rise and per zx_d_oe fall.
  initial begin
    logic prev_stb, prev_oe, prev_wrena;
    logic [7:0] last_dout;
    int low_w, high_w;
    prev_stb = 1'b1; prev_oe = 1'b0; prev_wrena = 1'b0;
    last_dout = 8'h00; low_w = 0; high_w = 0;
    forever begin
      @(negedge clk);
      if (port_wrstb_n === 1'b0) low_w++;
      if (zx_d_oe === 1'b1) begin
        high_w++;
        last_dout = zx_d_out;
      end
      if (port_wrena === 1'b1 && prev_wrena !== 1'b1) wrena_rises++;
      if (zx_d_oe === 1'b1 && prev_oe !== 1'b1) oe_rises++;
      if (prev_stb === 1'b0 && port_wrstb_n === 1'b1) begin
        score(mk(1'b0, port_addr, port_wrdata, port_wrena, low_w, 0));
        low_w = 0;
      end
      if (prev_oe === 1'b1 && zx_d_oe === 1'b0) begin
        score(mk(1'b1, port_addr, last_dout, 1'b0, high_w, cyc - rd_rel_cyc));
        high_w = 0;
      end
      prev_stb = port_wrstb_n; prev_oe = zx_d_oe; prev_wrena = port_wrena;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_release();
    zx_iorq_n = 1'b1; zx_rd_n = 1'b1; zx_wr_n = 1'b1; zx_m1_n = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    zx_a = a; zx_d_in = d;
    zx_iorq_n = 1'b0; zx_wr_n = 1'b0;
    wait_cyc(hold);
    bus_release();
    wait_cyc(8);
  endtask

  task automatic io_read(input logic [15:0] a, input int hold);
    zx_a = a;
    zx_iorq_n = 1'b0; zx_rd_n = 1'b0;
    wait_cyc(hold);
    rd_rel_cyc = cyc;
    bus_release();
    wait_cyc(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wrstb_n"}, 32'(port_wrstb_n), 32'd1);
    check({tag, "_wrena"}, 32'(port_wrena), 32'd0);
    check({tag, "_addr"}, 32'(port_addr), 32'd0);
    check({tag, "_wrdata"}, 32'(port_wrdata), 32'd0);
    check({tag, "_d_oe"}, 32'(zx_d_oe), 32'd0);
    check({tag, "_d_out"}, 32'(zx_d_out), 32'd0);
  endtask

  initial begin
    bit seen;
    wrstb_n = 1'b1;
    zx_a = 16'h0000; zx_d_in = 8'h00;
    bus_release();
    wait_cyc(3);
    check_reset_outputs("por");
    wrstb_n = 1'b0;
    wait_cyc(4);

    exp_q.push_back(mk(1'b0, 2'b11, 8'h34, 1'b1, 2, -1));
    io_write(16'h83AB, 8'h34, 8);

    // Bus releases before the strobe completes; the strobe must still be full width.
    exp_q.push_back(mk(1'b0, 2'b01, 8'h7F, 1'b1, 2, -1));
    io_write(16'h81AB, 8'h7F, 3);

    exp_q.push_back(mk(1'b1, 2'b10, 8'hE5, 1'b0, -1, 3));
    io_read(16'h82AB, 8);

    io_write(16'h80AB, 8'h11, 8);
    check("nohit_80ab_wrena", 32'(port_wrena), 32'd0);
    io_write(16'h81AC, 8'h22, 8);
    check("nohit_81ac_wrena", 32'(port_wrena), 32'd0);
    check("nohit_wrdata_kept", 32'(port_wrdata), 32'h7F);

    zx_a = 16'h81AB;
    zx_iorq_n = 1'b0; zx_m1_n = 1'b0;
    wait_cyc(10);
    check("inta_d_oe", 32'(zx_d_oe), 32'd0);
    check("inta_wrstb_n", 32'(port_wrstb_n), 32'd1);
    bus_release();
    wait_cyc(8);

    exp_q.push_back(mk(1'b1, 2'b01, 8'h5A, 1'b0, 255, -1));
    zx_a = 16'h81AB;
    zx_iorq_n = 1'b0; zx_rd_n = 1'b0;
    wait_cyc(300);
    check("timeout_no_restart", 32'(zx_d_oe), 32'd0);
    bus_release();
    wait_cyc(8);

    zx_a = 16'h82AB; zx_d_in = 8'h99;
    zx_iorq_n = 1'b0; zx_wr_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (port_wrstb_n === 1'b0) seen = 1'b1;
    end
    check("mid_wstb_reached", 32'(seen), 32'd1);
    exp_q.push_back(mk(1'b0, 2'b00, 8'h00, 1'b0, -1, -1));
    #1 wrstb_n = 1'b1;
    #1 check_reset_outputs("mid_wstb");
    bus_release();
    wait_cyc(3);
    wrstb_n = 1'b0;
    wait_cyc(8);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("oe_rise_count", 32'(oe_rises), 32'd2);
    check("wrena_rise_count", 32'(wrena_rises), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zxbus_port_ctrl.md
ZXBUS_PORT_CTRL -- requirements
Module: zxbus_port_ctrl

Interface
REQ-001 Parameter STB_CYCLES, default 2, sets port_wrstb_n low-pulse width in clk cycles (1..15).
REQ-002 Parameter TIMEOUT, default 255, sets the max clk cycles spent in RDRIVE or WAITEND (8-bit counter).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 wrstb_n  input  1  reset, asynchronous, active-high.
REQ-005 zx_a  input  16  ZX bus address.
REQ-006 zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n  input  1 each  ZX bus control, asynchronous to clk.
REQ-007 zx_d_in  input  8  ZX bus write data.
REQ-008 zx_d_out  output  8  read data toward ZX bus; zx_d_oe  output  1  bus driver enable.
REQ-009 port_addr  output  2  register select: 01=#81AB, 10=#82AB, 11=#83AB.
REQ-010 port_wrdata  output  8  write data to the port register file.
REQ-011 port_wrena  output  1  write qualifier, valid across the port_wrstb_n rising edge.
REQ-012 port_wrstb_n  output  1  write strobe; the register file latches on its rising edge.
REQ-013 port_rddata  input  8  combinational read data for port_addr.

Function
REQ-014 zx_iorq_n, zx_rd_n, zx_wr_n and zx_m1_n SHALL pass a 2-FF synchronizer; all decisions use synchronized values.
REQ-015 Hit SHALL be: zx_a[7:0]==8'hAB, zx_a[15:10]==6'b100000, zx_a[9:8]!=2'b00; port_addr SHALL be zx_a[9:8], captured at cycle start.
REQ-016 A cycle starts when sync iorq=0, m1=1 and exactly one of rd/wr is 0; iorq=0 with m1=0 (INTA) SHALL be ignored.
REQ-017 States: IDLE, WSETUP, WSTB, RDRIVE, WAITEND.
REQ-018 IDLE: write hit -> WSETUP, capture zx_d_in into port_wrdata; read hit -> RDRIVE; non-hit or rd=wr=0 -> WAITEND.
REQ-019 WSETUP: port_wrena=1, port_wrstb_n=1 for exactly 1 cycle, then WSTB.
REQ-020 WSTB: port_wrstb_n=0 for exactly STB_CYCLES cycles, then port_wrstb_n=1 and -> WAITEND; port_wrena SHALL stay 1 for 1 cycle after the rising edge, then 0.
REQ-021 WSTB SHALL run to completion regardless of bus activity; exactly one strobe per write cycle.
REQ-022 RDRIVE: zx_d_oe=1, zx_d_out SHALL register port_rddata every cycle (1-cycle latency); on sync iorq=1 or rd=1, zx_d_oe SHALL drop next edge and -> IDLE.
REQ-023 WAITEND: -> IDLE when sync iorq, rd, wr all 1.
REQ-024 A cycle counter SHALL clear on every state change; reaching TIMEOUT in RDRIVE or WAITEND SHALL force IDLE with zx_d_oe=0.
REQ-025 After returning to IDLE, a new cycle SHALL NOT start until iorq has been sampled high for at least 1 cycle.

Reset
REQ-026 On wrstb_n=1, immediately: state IDLE, port_wrstb_n=1, port_wrena=0, port_addr=00, port_wrdata=00, zx_d_oe=0, zx_d_out=00, counter and synchronizers to idle-high.
REQ-027 Reset during WSTB SHALL clear port_wrena in the same instant port_wrstb_n rises, so no register write occurs.

Structure
REQ-028 Shared package zxnet_pkg SHALL hold port address constants (2'b01/10/11), the AB low-byte and 6'b100000 prefix constants, and the state enum.
REQ-029 One sub-module, zx_sync2 (2-FF synchronizer, parameterized width), SHALL be instantiated for the 4 control lines.

Verification
REQ-030 Write #83AB data 8'h34 -> one port_wrstb_n low pulse of 2 cycles, port_addr=11, port_wrdata=34, port_wrena=1 through rising edge.
REQ-031 Read #82AB with port_rddata=8'hE5 -> zx_d_oe=1, zx_d_out=E5 until rd rises, zx_d_oe=0 within 3 clk of rd high.
REQ-032 Write #80AB and #81AC -> no strobe, port_wrena stays 0, returns IDLE at cycle end.
REQ-033 iorq=0, m1=0 at #81AB (INTA) -> no strobe, zx_d_oe=0.
REQ-034 wrstb_n asserted mid-WSTB -> port_wrstb_n=1 and port_wrena=0 together, all outputs at reset values.
REQ-035 Read #81AB with rd held low 300 cycles -> zx_d_oe drops after 255 cycles in RDRIVE; no new cycle until iorq high.
